char_writer: RTL and testbench

CHAR_WRITER -- requirements
Module: char_writer

---
 rtl/char_writer_if.sv | 22 ++
 rtl/char_writer.sv | 159 +++++++++++++++
 tb/tb_char_writer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/char_writer_if.sv
// Byte-input handshake and video RAM write port for char_writer.
// master: the side offering bytes and granting RAM slots.
// slave:  the char_writer itself.
interface char_writer_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        ram_grant;
  logic        ram_wren;
  logic [15:0] ram_address;
  logic [7:0]  ram_data;

  modport master (
    output in_valid, in_data, ram_grant,
    input  in_ready, ram_wren, ram_address, ram_data
  );

  modport slave (
    input  in_valid, in_data, ram_grant,
    output in_ready, ram_wren, ram_address, ram_data
  );
endinterface

// File: rtl/char_writer.sv
// Character writer: turns a byte stream into video RAM writes at a text cursor.
// Handles printable bytes, CR, LF (with line clear), BS and FF (full clear).
// Optional feature macro: CHAR_WRITER_AUTOWRAP_EN -- when defined, a write into the
// last visible column wraps the cursor to the next row and clears that row;
// otherwise the column saturates at COLS-1.
module char_writer #(
  parameter int unsigned COLS = 52,
  parameter int unsigned ROWS = 24
) (
  input  logic           clk,
  input  logic           reset_n,
  char_writer_if.slave   bus,
  output logic [4:0]     cursor_row,
  output logic [6:0]     cursor_col,
  output logic           busy
);

  typedef enum logic [1:0] {StIdle, StWrite, StClrLine, StClrScreen} state_e;

  localparam logic [4:0] LastRow = 5'(ROWS - 1);
  localparam logic [6:0] LastCol = 7'(COLS - 1);
  localparam logic [7:0] Space   = 8'h20;

  state_e      r_state;
  logic        r_ready;
  logic        r_wren;
  logic [15:0] r_addr;
  logic [7:0]  r_data;
  logic [4:0]  r_row;
  logic [6:0]  r_col;

  logic        w_accept;
  logic        w_printable;
  logic [4:0]  w_next_row;

  assign w_accept    = bus.in_valid && r_ready;
  assign w_printable = (bus.in_data >= 8'h20) && (bus.in_data <= 8'h7E);
  // No scrolling: the row after the last visible one is row 0.
  assign w_next_row  = (r_row == LastRow) ? 5'd0 : r_row + 5'd1;

  assign bus.in_ready    = r_ready;
  assign bus.ram_wren    = r_wren;
  assign bus.ram_address = r_addr;
  assign bus.ram_data    = r_data;
  assign cursor_row      = r_row;
  assign cursor_col      = r_col;
  assign busy            = (r_state != StIdle);

  // FSM: byte decode, write handshake with the RAM arbiter, and clear sweeps.
  // The RAM address register doubles as the clear counter; it only advances on
  // granted cycles so every cell is written exactly once.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_ready <= 1'b0;
      r_wren  <= 1'b0;
      r_addr  <= 16'hF000;
      r_data  <= 8'h00;
      r_row   <= 5'd0;
      r_col   <= 7'd0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            if (w_printable) begin
              r_state <= StWrite;
              r_ready <= 1'b0;
              r_wren  <= 1'b1;
              r_addr  <= {4'hF, r_row, r_col};
              r_data  <= bus.in_data;
            end else begin
              case (bus.in_data)
                8'h0D: r_col <= 7'd0;
                8'h08: begin
                  if (r_col != 7'd0) r_col <= r_col - 7'd1;
                end
                8'h0A: begin
                  r_row   <= w_next_row;
                  r_state <= StClrLine;
                  r_ready <= 1'b0;
                  r_wren  <= 1'b1;
                  r_addr  <= {4'hF, w_next_row, 7'd0};
                  r_data  <= Space;
                end
                8'h0C: begin
                  r_row   <= 5'd0;
                  r_col   <= 7'd0;
                  r_state <= StClrScreen;
                  r_ready <= 1'b0;
                  r_wren  <= 1'b1;
                  r_addr  <= 16'hF000;
                  r_data  <= Space;
                end
                default: ;  // accepted and discarded
              endcase
            end
          end
        end

        StWrite: begin
          if (bus.ram_grant) begin
            r_wren <= 1'b0;
            if (r_col == LastCol) begin
`ifdef CHAR_WRITER_AUTOWRAP_EN
              r_col   <= 7'd0;
              r_row   <= w_next_row;
              r_state <= StClrLine;
              r_wren  <= 1'b1;
              r_addr  <= {4'hF, w_next_row, 7'd0};
              r_data  <= Space;
`else
              // Saturate: the next printable byte overwrites this cell.
              r_state <= StIdle;
              r_ready <= 1'b1;
`endif
            end else begin
              r_col   <= r_col + 7'd1;
              r_state <= StIdle;
              r_ready <= 1'b1;
            end
          end
        end

        StClrLine: begin
          if (bus.ram_grant) begin
            if (r_addr[6:0] == 7'h7F) begin
              r_wren  <= 1'b0;
              r_col   <= 7'd0;
              r_state <= StIdle;
              r_ready <= 1'b1;
            end else begin
              r_addr <= r_addr + 16'd1;
            end
          end
        end

        StClrScreen: begin
          if (bus.ram_grant) begin
            if (r_addr[11:0] == 12'hFFF) begin
              r_wren  <= 1'b0;
              r_state <= StIdle;
              r_ready <= 1'b1;
            end else begin
              r_addr <= r_addr + 16'd1;
            end
          end
        end

        default: begin
          r_state <= StIdle;
          r_wren  <= 1'b0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_char_writer.sv
// Self-checking bench for char_writer: a table of single-byte transactions plus
// hand-written sequences for reset, grant stalls, row wrap, line wrap and reset
// during a screen clear.
module tb_char_writer;

  logic clk = 1'b0;
  logic reset_n;
  logic [4:0] cursor_row;
  logic [6:0] cursor_col;
  logic busy;

  char_writer_if bus_if ();

  char_writer #(.COLS(52), .ROWS(24)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus_if.slave),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Write monitor: a RAM write happens on a cycle with wren and grant both high.
  int unsigned wr_cnt;
  logic [15:0] wr_first, wr_last;
  logic [7:0]  wr_data;
  logic        wr_order_err;

  always @(negedge clk) begin
    if (reset_n && bus_if.ram_wren && bus_if.ram_grant) begin
      if (wr_cnt == 0) wr_first = bus_if.ram_address;
      else if (bus_if.ram_address != wr_last + 16'd1) wr_order_err = 1'b1;
      wr_last = bus_if.ram_address;
      wr_data = bus_if.ram_data;
      wr_cnt  = wr_cnt + 1;
    end
  end

  task automatic clear_mon();
    wr_cnt       = 0;
    wr_first     = 16'h0;
    wr_last      = 16'h0;
    wr_data      = 8'h0;
    wr_order_err = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Offer one byte, wait for acceptance, then wait until the writer is idle again.
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_if.in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    if (!ok) begin timeout_fail("accept"); return; end
    ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (bus_if.in_ready && !busy) begin ok = 1'b1; break; end
    end
    if (!ok) timeout_fail("idle");
  endtask

  typedef struct {
    logic [7:0]  ch;
    int unsigned n_wr;
    logic [15:0] first;
    logic [15:0] last;
    logic [7:0]  data;
    logic [4:0]  row;
    logic [6:0]  col;
  } vec_t;

  vec_t vecs [12];

  initial begin
    // Starting cursor for the table is (0,1), after the first 'A' sequence.
    vecs[0]  = '{8'h42, 1,    16'hF001, 16'hF001, 8'h42, 5'd0, 7'd2};
    vecs[1]  = '{8'h08, 0,    16'h0,    16'h0,    8'h00, 5'd0, 7'd1};
    vecs[2]  = '{8'h0D, 0,    16'h0,    16'h0,    8'h00, 5'd0, 7'd0};
    vecs[3]  = '{8'h08, 0,    16'h0,    16'h0,    8'h00, 5'd0, 7'd0};
    vecs[4]  = '{8'h7F, 0,    16'h0,    16'h0,    8'h00, 5'd0, 7'd0};
    vecs[5]  = '{8'h80, 0,    16'h0,    16'h0,    8'h00, 5'd0, 7'd0};
    vecs[6]  = '{8'h0A, 128,  16'hF080, 16'hF0FF, 8'h20, 5'd1, 7'd0};
    vecs[7]  = '{8'h7E, 1,    16'hF080, 16'hF080, 8'h7E, 5'd1, 7'd1};
    vecs[8]  = '{8'h20, 1,    16'hF081, 16'hF081, 8'h20, 5'd1, 7'd2};
    vecs[9]  = '{8'hFF, 0,    16'h0,    16'h0,    8'h00, 5'd1, 7'd2};
    vecs[10] = '{8'h0C, 4096, 16'hF000, 16'hFFFF, 8'h20, 5'd0, 7'd0};
    vecs[11] = '{8'h09, 0,    16'h0,    16'h0,    8'h00, 5'd0, 7'd0};

    reset_n          = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = 8'h00;
    bus_if.ram_grant = 1'b1;
    clear_mon();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst in_ready", bus_if.in_ready, 0);
    check("rst wren", bus_if.ram_wren, 0);
    check("rst busy", busy, 0);
    check("rst addr", bus_if.ram_address, 16'hF000);
    check("rst data", bus_if.ram_data, 8'h00);
    check("rst cursor", {cursor_row, cursor_col}, 12'h000);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("post-rst in_ready", bus_if.in_ready, 1);

    // First printable byte: one-cycle write, ready again after the grant edge
    @(posedge clk); #1;
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 8'h41;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    @(negedge clk);
    check("A wren", bus_if.ram_wren, 1);
    check("A addr", bus_if.ram_address, 16'hF000);
    check("A data", bus_if.ram_data, 8'h41);
    check("A ready low", bus_if.in_ready, 0);
    check("A busy", busy, 1);
    @(negedge clk);
    check("A wren done", bus_if.ram_wren, 0);
    check("A ready back", bus_if.in_ready, 1);
    check("A col", cursor_col, 7'd1);

    // Table of single-byte transactions
    for (int i = 0; i < 12; i++) begin
      clear_mon();
      send_byte(vecs[i].ch);
      check($sformatf("v%0d writes", i), wr_cnt, vecs[i].n_wr);
      check($sformatf("v%0d row", i), cursor_row, vecs[i].row);
      check($sformatf("v%0d col", i), cursor_col, vecs[i].col);
      if (vecs[i].n_wr != 0) begin
        check($sformatf("v%0d first", i), wr_first, vecs[i].first);
        check($sformatf("v%0d last", i), wr_last, vecs[i].last);
        check($sformatf("v%0d data", i), wr_data, vecs[i].data);
        check($sformatf("v%0d order", i), wr_order_err, 0);
      end
    end

    // Grant withheld for 5 cycles: write held stable, completes on first grant
    clear_mon();
    @(posedge clk); #1;
    bus_if.ram_grant = 1'b0;
    bus_if.in_valid  = 1'b1;
    bus_if.in_data   = 8'h55;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d bus", i),
            {bus_if.ram_wren, bus_if.ram_address, bus_if.ram_data}, {1'b1, 16'hF000, 8'h55});
    end
    @(posedge clk); #1;
    bus_if.ram_grant = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("stall wren done", bus_if.ram_wren, 0);
    check("stall writes", wr_cnt, 1);
    check("stall col", cursor_col, 7'd1);

    // Row wrap: LF from the last row goes to row 0 and clears it
    send_byte(8'h0D);
    for (int i = 0; i < 23; i++) send_byte(8'h0A);
    check("row 23", cursor_row, 5'd23);
    clear_mon();
    send_byte(8'h0A);
    check("wrap row", cursor_row, 5'd0);
    check("wrap writes", wr_cnt, 128);
    check("wrap first", wr_first, 16'hF000);
    check("wrap last", wr_last, 16'hF07F);
    clear_mon();
    send_byte(8'h0D);
    send_byte(8'h08);
    check("cr bs col", cursor_col, 7'd0);
    check("cr bs writes", wr_cnt, 0);

    // Filling a full row of 52 columns
    clear_mon();
    for (int i = 0; i < 52; i++) send_byte(8'h61 + 8'(i % 26));
`ifdef CHAR_WRITER_AUTOWRAP_EN
    check("fill cursor", {cursor_row, cursor_col}, {5'd1, 7'd0});
    check("fill writes", wr_cnt, 180);
    check("fill last", wr_last, 16'hF0FF);
    check("fill last data", wr_data, 8'h20);
`else
    check("fill cursor", {cursor_row, cursor_col}, {5'd0, 7'd51});
    check("fill writes", wr_cnt, 52);
    check("fill last", wr_last, 16'hF033);
    clear_mon();
    send_byte(8'h5A);
    check("sat writes", wr_cnt, 1);
    check("sat addr", wr_last, 16'hF033);
    check("sat data", wr_data, 8'h5A);
    check("sat col", cursor_col, 7'd51);
`endif

    // Reset during a screen clear aborts it
    @(posedge clk); #1;
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 8'h0C;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("mid clear busy", busy, 1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    clear_mon();
    @(negedge clk);
    check("abort wren", bus_if.ram_wren, 0);
    check("abort busy", busy, 0);
    check("abort cursor", {cursor_row, cursor_col}, 12'h000);
    check("abort in_ready", bus_if.in_ready, 0);
    repeat (3) @(negedge clk);
    check("abort no writes", wr_cnt, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort ready back", bus_if.in_ready, 1);
    check("abort idle wren", bus_if.ram_wren, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
